// File: rtl/exec_stage.sv
// Y86-64 execute stage: ALU operand select, condition codes, branch/cmov condition, valid/ready output register.
// Optional EXEC_STAT_EN adds out_stat and a sticky halted flag that blocks further input.

module alu #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   control,
  output logic [W-1:0] out,
  output logic         overflow
);
  always_comb begin
    out      = '0;
    overflow = 1'b0;
    unique case (control)
      2'b00: begin
        out      = a + b;
        overflow = (a[W-1] == b[W-1]) && (out[W-1] != a[W-1]);
      end
      2'b01: begin
        out      = a - b;
        overflow = (a[W-1] != b[W-1]) && (out[W-1] != a[W-1]);
      end
      2'b10:   out = a & b;
      default: out = a ^ b;
    endcase
  end
endmodule

module exec_stage #(
  parameter int unsigned W          = 64,
  parameter int unsigned STACK_STEP = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_icode,
  output logic [W-1:0] out_valE,
  output logic [W-1:0] out_valA,
  output logic         out_cnd,
`ifdef EXEC_STAT_EN
  output logic [1:0]   out_stat,
`endif
  output logic [2:0]   cc
);
  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [1:0]   alu_ctl;
  logic         alu_ovf;
  logic         op_ok, xfer, cnd_c, lt;

  assign op_ok = (icode == I_OPQ) && (ifun <= 4'd3);

`ifdef EXEC_STAT_EN
  logic       halted;
  logic       ins;
  logic [1:0] stat_c;
  assign ins      = (icode > I_POP) || ((icode == I_OPQ) && (ifun > 4'd3));
  assign stat_c   = (icode == I_HALT) ? 2'd1 : (ins ? 2'd2 : 2'd0);
  assign in_ready = (!out_valid || out_ready) && !halted;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign xfer = in_valid && in_ready;

  // Operand/function selection; unsupported encodings feed zeros so valE is 0.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctl = ALU_ADD;
    case (icode)
      I_RRMOV: alu_a = valA;
      I_IRMOV: alu_a = valC;
      I_RMMOV, I_MRMOV: begin
        alu_a = valB;
        alu_b = valC;
      end
      I_OPQ: if (op_ok) begin
        alu_a   = valB;
        alu_b   = valA;
        alu_ctl = ifun[1:0];
      end
      I_CALL, I_PUSH: begin
        alu_a   = valB;
        alu_b   = W'(STACK_STEP);
        alu_ctl = ALU_SUB;
      end
      I_RET, I_POP: begin
        alu_a = valB;
        alu_b = W'(STACK_STEP);
      end
      default: ;
    endcase
  end

  alu #(.W(W)) u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .control  (alu_ctl),
    .out      (alu_out),
    .overflow (alu_ovf)
  );

  // Condition from the pre-update CC: cc = {ZF,SF,OF}.
  always_comb begin
    lt    = cc[1] ^ cc[0];
    cnd_c = 1'b0;
    if ((icode == I_RRMOV) || (icode == I_JXX)) begin
      case (ifun)
        4'd0:    cnd_c = 1'b1;
        4'd1:    cnd_c = lt | cc[2];
        4'd2:    cnd_c = lt;
        4'd3:    cnd_c = cc[2];
        4'd4:    cnd_c = !cc[2];
        4'd5:    cnd_c = !lt;
        4'd6:    cnd_c = !lt && !cc[2];
        default: cnd_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_icode <= '0;
      out_valE  <= '0;
      out_valA  <= '0;
      out_cnd   <= 1'b0;
`ifdef EXEC_STAT_EN
      out_stat  <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_icode <= icode;
      out_valE  <= alu_out;
      out_valA  <= valA;
      out_cnd   <= cnd_c;
`ifdef EXEC_STAT_EN
      out_stat  <= stat_c;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= 3'b100;
    end else if (xfer && op_ok) begin
      cc <= {alu_out == '0, alu_out[W-1], alu_ovf};
    end
  end

`ifdef EXEC_STAT_EN
  // Sticky until reset once a HLT or INS entry is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (xfer && (stat_c != 2'd0)) begin
      halted <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_exec_stage;
  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, out_cnd;
  logic [3:0]   icode, ifun, out_icode;
  logic [W-1:0] valA, valB, valC, out_valE, out_valA;
  logic [2:0]   cc;
`ifdef EXEC_STAT_EN
  logic [1:0]   out_stat;
`endif

  exec_stage #(.W(W), .STACK_STEP(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_icode (out_icode),
    .out_valE  (out_valE),
    .out_valA  (out_valA),
    .out_cnd   (out_cnd),
`ifdef EXEC_STAT_EN
    .out_stat  (out_stat),
`endif
    .cc        (cc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic         m_valid, m_cnd, m_halted;
  logic [3:0]   m_icode;
  logic [W-1:0] m_valE, m_valA;
  logic [2:0]   m_cc;
  logic [1:0]   m_stat;

  function automatic logic cond_ok(input logic [3:0] f, input logic [2:0] c);
    bit zf = c[2];
    bit lt = (c[1] != c[0]);
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Y86 semantics in signed arithmetic; ov reports signed overflow for addq/subq.
  function automatic logic [W-1:0] ref_valE(input logic [3:0] ic, input logic [3:0] f,
      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c, output logic ov);
    longint sa = longint'(a);
    longint sb = longint'(b);
    longint r;
    ov = 1'b0;
    case (ic)
      4'h2: return a;
      4'h3: return c;
      4'h4, 4'h5: return b + c;
      4'h6: begin
        case (f)
          4'd0: begin r = sb + sa; ov = ((sa < 0) == (sb < 0)) && ((r < 0) != (sb < 0)); return W'(r); end
          4'd1: begin r = sb - sa; ov = ((sa < 0) != (sb < 0)) && ((r < 0) != (sb < 0)); return W'(r); end
          4'd2: return a & b;
          4'd3: return a ^ b;
          default: return '0;
        endcase
      end
      4'h8, 4'hA: return b - 64'd8;
      4'h9, 4'hB: return b + 64'd8;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_cnd = 1'b0; m_halted = 1'b0; m_icode = '0;
    m_valE = '0; m_valA = '0; m_cc = 3'b100; m_stat = '0;
  endtask

  task automatic compare_outputs();
    check("out_valid", out_valid, m_valid);
    check("cc", cc, m_cc);
    if (m_valid) begin
      check("out_icode", out_icode, m_icode);
      check("out_valE", out_valE, m_valE);
      check("out_valA", out_valA, m_valA);
      check("out_cnd", out_cnd, m_cnd);
`ifdef EXEC_STAT_EN
      check("out_stat", out_stat, m_stat);
`endif
    end
  endtask

  // One cycle: drive at posedge+1, check in_ready, advance, update model, compare.
  task automatic step(input logic v, input logic [3:0] ic, input logic [3:0] f,
      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c, input logic ordy);
    logic exp_ready, tr, ov, bad;
    logic [W-1:0] e;
    in_valid = v; icode = ic; ifun = f; valA = a; valB = b; valC = c; out_ready = ordy;
    #1;
    exp_ready = (!m_valid || ordy) && !m_halted;
    check("in_ready", in_ready, exp_ready);
    tr = v && exp_ready;
    @(posedge clk);
    if (tr) begin
      e   = ref_valE(ic, f, a, b, c, ov);
      bad = (ic > 4'hB) || (ic == 4'h6 && f > 4'd3);
      m_cnd   = (ic == 4'h2 || ic == 4'h7) ? cond_ok(f, m_cc) : 1'b0;
      m_valid = 1'b1; m_icode = ic; m_valE = e; m_valA = a;
      m_stat  = (ic == 4'h0) ? 2'd1 : (bad ? 2'd2 : 2'd0);
      if (ic == 4'h6 && f <= 4'd3) m_cc = {e == '0, e[W-1], ov};
`ifdef EXEC_STAT_EN
      if (m_stat != 2'd0) m_halted = 1'b1;
`endif
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_cc", cc, 3'b100);
    check("rst_out_valE", out_valE, '0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] ic, f;
    do_reset();

    step(1, 4'h6, 4'd0, 64'd4, 64'd11, 0, 1);
    check("addq_valE", out_valE, 64'd15);
    check("addq_cc", cc, 3'b000);
    step(1, 4'h6, 4'd1, 64'd4, 64'd4, 0, 1);
    check("subq_valE", out_valE, 64'd0);
    check("subq_cc", cc, 3'b100);
    step(1, 4'h7, 4'd3, 0, 0, 64'h40, 1);
    check("je_cnd", out_cnd, 1'b1);
    step(1, 4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1);
    check("ovf_valE", out_valE, 64'h8000_0000_0000_0000);
    check("ovf_cc", cc, 3'b011);
    step(1, 4'h2, 4'd2, 64'd9, 0, 0, 1);
    check("cmovl_cnd", out_cnd, 1'b0);
    step(1, 4'hA, 4'd0, 64'd3, 64'h100, 0, 1);
    check("push_valE", out_valE, 64'hF8);
    check("push_cc", cc, 3'b011);
    step(1, 4'hB, 4'd0, 0, 64'hF8, 0, 1);
    check("pop_valE", out_valE, 64'h100);

    // Stall with a pending OPq
    repeat (3) begin
      step(1, 4'h6, 4'd0, 64'd5, 64'd9, 0, 0);
      check("stall_valE", out_valE, 64'h100);
      check("stall_cc", cc, 3'b011);
    end
    step(1, 4'h6, 4'd0, 64'd5, 64'd9, 0, 1);
    check("unstall_valE", out_valE, 64'd14);
    check("unstall_cc", cc, 3'b000);

    // Invalid icode and OPq ifun passthrough in the default build
`ifndef EXEC_STAT_EN
    step(1, 4'hE, 4'd0, 64'd7, 64'd7, 64'd7, 1);
    check("ins_valE", out_valE, 64'd0);
    step(1, 4'h6, 4'd5, 64'd7, 64'd7, 0, 1);
    check("opq_bad_valE", out_valE, 64'd0);
    check("opq_bad_cc", cc, 3'b000);
`endif

    // Reset asserted mid-stall
    step(1, 4'h3, 4'd0, 0, 0, 64'h55, 0);
    step(1, 4'h6, 4'd0, 64'd1, 64'd1, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midstall_rst_valid", out_valid, 1'b0);
    check("midstall_rst_cc", cc, 3'b100);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
`ifdef EXEC_STAT_EN
      ic = 4'($urandom_range(1, 11));
`else
      ic = 4'($urandom_range(0, 15));
`endif
      f = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
`ifndef EXEC_STAT_EN
      if (ic == 4'h6 && $urandom_range(0, 7) == 0) f = 4'($urandom_range(4, 15));
`endif
      step($urandom_range(0, 3) != 0, ic, f,
           {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
           {$urandom, $urandom}, $urandom_range(0, 9) < 7);
    end

`ifdef EXEC_STAT_EN
    do_reset();
    step(1, 4'h0, 4'd0, 0, 0, 0, 1);
    check("hlt_stat", out_stat, 2'd1);
    repeat (3) begin
      step(1, 4'h1, 4'd0, 0, 0, 0, 1);
      check("halted_ready", in_ready, 1'b0);
    end
    do_reset();
    #1;
    check("post_rst_ready", in_ready, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
